sensor_conditioner: RTL and testbench

Front-end conditioning stage of the irrigation controller: takes the raw, asynchronous field-sensor lines (three tank-level probes, soil-dry probe, over-temperature switch), synchronizes and debounces each one, and checks tank-level consistency. Its outputs are the clean sensor flags sampled by the downstream state/register flip-flops that drive the pump and valve logic. It also supplies a startup-valid flag and a one-cycle change strobe so downstream logic samples only settled values.

---
 rtl/sensor_conditioner.sv | 152 +++++++++++++++
 tb/tb_sensor_conditioner.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_conditioner.sv
// sensor_conditioner: synchronizes, debounces and sanity-checks the raw
// irrigation field-sensor lines before the pump/valve logic samples them.
//
// Ports:
//   CLK      in   system clock, rising edge
//   RESET    in   asynchronous active-low reset
//   raw_lvl  in   [2:0] tank probes (bit0 low, bit1 mid, bit2 high), async
//   raw_dry  in   soil-dry probe, async
//   raw_hot  in   over-temperature switch, async
//   lvl      out  [2:0] debounced tank level
//   dry      out  debounced soil-dry flag
//   hot      out  debounced over-temperature flag
//   lvl_err  out  debounced level is not a thermometer code (gated by valid)
//   changed  out  one-cycle strobe: a debounced output changed this edge
//   valid    out  outputs settled since reset (sticky)
module sensor_conditioner #(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned CNT_W      = 5
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [2:0] raw_lvl,
    input  logic       raw_dry,
    input  logic       raw_hot,
    output logic [2:0] lvl,
    output logic       dry,
    output logic       hot,
    output logic       lvl_err,
    output logic       changed,
    output logic       valid
);

    localparam int unsigned NCH = 5;

    localparam logic [CNT_W-1:0] CNT_MAX =
        CNT_W'(DEB_CYCLES - 1);

    // Startup counter is one bit wider so DEB_CYCLES+2 always fits.
    localparam logic [CNT_W:0] ST_DONE =
        (CNT_W + 1)'(DEB_CYCLES + 2);

    // Channel order: [2:0] level probes, [3] dry, [4] hot.
    logic [NCH-1:0]   raw_v;

    logic [NCH-1:0]   sync1_q;
    logic [NCH-1:0]   sync2_q;

    logic [NCH-1:0]   s_q;
    logic [NCH-1:0]   s_d;

    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];

    logic [CNT_W:0]   st_q;
    logic [CNT_W:0]   st_d;

    logic             valid_q;
    logic             valid_d;

    logic             lvl_err_q;
    logic             lvl_err_d;

    logic             changed_q;
    logic             changed_d;

    assign raw_v = {raw_hot, raw_dry, raw_lvl};

    // Legal tank readings are thermometer codes: a higher probe can only
    // be wet if every probe below it is wet too.
    function automatic logic lvl_legal(input logic [2:0] l);
        logic ok;
        case (l)
            3'b000, 3'b001,
            3'b011, 3'b111: ok = 1'b1;
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // ---------------------------------------------------------------
    // Debounce next-state: any cycle of agreement restarts the window,
    // so only a level held for DEB_CYCLES synchronized cycles is taken.
    // ---------------------------------------------------------------
    always_comb begin
        s_d = s_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != s_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    s_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Startup qualification and derived flags.
    // ---------------------------------------------------------------
    always_comb begin
        st_d = st_q;
        if (st_q != ST_DONE) begin
            st_d = st_q + 1'b1;
        end

        valid_d = (st_d == ST_DONE);

        // Error reflects the level being published on this same edge.
        lvl_err_d = valid_d & ~lvl_legal(s_d[2:0]);

        // Initial settling updates are not reported as changes.
        changed_d = valid_q & (s_d != s_q);
    end

    // ---------------------------------------------------------------
    // State registers.
    // ---------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            s_q       <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
            st_q      <= '0;
            valid_q   <= 1'b0;
            lvl_err_q <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            sync1_q   <= raw_v;
            sync2_q   <= sync1_q;
            s_q       <= s_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            st_q      <= st_d;
            valid_q   <= valid_d;
            lvl_err_q <= lvl_err_d;
            changed_q <= changed_d;
        end
    end

    assign lvl     = s_q[2:0];
    assign dry     = s_q[3];
    assign hot     = s_q[4];
    assign lvl_err = lvl_err_q;
    assign changed = changed_q;
    assign valid   = valid_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// tb_sensor_conditioner: directed stimulus for sensor_conditioner with a
// window-based reference model compared every cycle plus literal checks.
module tb_sensor_conditioner;

    localparam int D = 4;

    logic       CLK     = 1'b0;
    logic       RESET   = 1'b0;
    logic [2:0] raw_lvl = 3'b000;
    logic       raw_dry = 1'b0;
    logic       raw_hot = 1'b0;

    logic [2:0] lvl;
    logic       dry;
    logic       hot;
    logic       lvl_err;
    logic       changed;
    logic       valid;

    int checks   = 0;
    int failures = 0;

    logic [7:0] outs;
    assign outs = {lvl, dry, hot, lvl_err, changed, valid};

    sensor_conditioner #(
        .DEB_CYCLES(D),
        .CNT_W     (5)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .raw_lvl(raw_lvl),
        .raw_dry(raw_dry),
        .raw_hot(raw_hot),
        .lvl    (lvl),
        .dry    (dry),
        .hot    (hot),
        .lvl_err(lvl_err),
        .changed(changed),
        .valid  (valid)
    );

    always #5 CLK = ~CLK;

    // Reference model: a level is accepted once the synchronized input
    // (raw delayed two edges) has disagreed with the current output for
    // D consecutive samples. smp[0] is the newest raw sample.
    logic [4:0] smp [0:D] = '{default: '0};
    logic [4:0] ms     = '0;
    logic [4:0] nxt;
    int         ec     = 0;
    logic       mvalid = 1'b0;
    logic       mchg   = 1'b0;
    logic       merr   = 1'b0;
    logic       pv;
    logic       agree;

    function automatic logic legal(input logic [2:0] l);
        return (l == 3'd0) || (l == 3'd1) || (l == 3'd3) || (l == 3'd7);
    endfunction

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int j = 0; j <= D; j++) smp[j] = '0;
            ms     = '0;
            ec     = 0;
            mvalid = 1'b0;
            mchg   = 1'b0;
            merr   = 1'b0;
        end else begin
            nxt = ms;
            for (int c = 0; c < 5; c++) begin
                agree = 1'b0;
                for (int j = 1; j <= D; j++) begin
                    if (smp[j][c] == ms[c]) agree = 1'b1;
                end
                if (!agree) nxt[c] = ~ms[c];
            end
            pv = mvalid;
            if (ec < D + 2) ec++;
            mvalid = (ec == D + 2);
            mchg   = pv && (nxt != ms);
            ms     = nxt;
            merr   = mvalid && !legal(ms[2:0]);
            for (int j = D; j > 0; j--) smp[j] = smp[j-1];
            smp[0] = {raw_hot, raw_dry, raw_lvl};
        end
    end

    logic [7:0] mexp;
    always @(negedge CLK) begin
        mexp = {ms[2:0], ms[3], ms[4], merr, mchg, mvalid};
        checks++;
        if (outs !== mexp) begin
            failures++;
            $display("FAIL model_cmp t=%0t got %b want %b",
                     $time, outs, mexp);
        end
    end

    task automatic chk(input string nm, input logic [7:0] exp);
        checks++;
        if (outs !== exp) begin
            failures++;
            $display("FAIL %s got %b want %b", nm, outs, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got %b want %b", nm, act, exp);
        end
    endtask

    logic seen_chg = 1'b0;
    logic seen_hot = 1'b0;

    task automatic run(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            seen_chg = seen_chg | changed;
            seen_hot = seen_hot | hot;
        end
    endtask

    task automatic do_reset(input logic [2:0] l, input logic d,
                            input logic h);
        raw_lvl = l;
        raw_dry = d;
        raw_hot = h;
        RESET   = 1'b0;
        run(3);
        chk("reset_zero", 8'h00);
        RESET = 1'b1;
    endtask

    initial begin
        // Quiet startup: valid on edge 6, nothing else moves.
        do_reset(3'b000, 1'b0, 1'b0);
        run(5);
        chk("t1_e5", 8'b000_0_0_0_0_0);
        run(1);
        chk("t1_e6", 8'b000_0_0_0_0_1);
        seen_chg = 1'b0;
        run(10);
        chkb("t1_no_chg", seen_chg, 1'b0);

        // Level held through reset appears with valid, no strobe.
        do_reset(3'b011, 1'b0, 1'b0);
        run(5);
        chk("t2_e5", 8'b000_0_0_0_0_0);
        run(1);
        chk("t2_e6", 8'b011_0_0_0_0_1);

        // Dry rises: accepted on E0+5 with a single strobe.
        run(3);
        raw_dry = 1'b1;
        run(5);
        chk("t3_e4", 8'b011_0_0_0_0_1);
        run(1);
        chk("t3_e5", 8'b011_1_0_0_1_1);
        run(1);
        chk("t3_e6", 8'b011_1_0_0_0_1);

        // Hot pulse of 3 cycles is rejected.
        seen_chg = 1'b0;
        seen_hot = 1'b0;
        raw_hot  = 1'b1;
        run(3);
        raw_hot  = 1'b0;
        run(10);
        chkb("t4_short_hot", seen_hot, 1'b0);
        chkb("t4_short_chg", seen_chg, 1'b0);

        // Hot pulse of 4 cycles is accepted on E0+5.
        raw_hot = 1'b1;
        run(4);
        raw_hot = 1'b0;
        run(1);
        chk("t4_long_e4", 8'b011_1_0_0_0_1);
        run(1);
        chk("t4_long_e5", 8'b011_1_1_0_1_1);
        run(10);
        chk("t4_hot_back", 8'b011_1_0_0_0_1);

        // Illegal level 101 is passed through with lvl_err.
        raw_lvl = 3'b000;
        run(12);
        chk("t5_lvl0", 8'b000_1_0_0_0_1);
        raw_lvl = 3'b101;
        run(5);
        chk("t5_e4", 8'b000_1_0_0_0_1);
        run(1);
        chk("t5_101", 8'b101_1_0_1_1_1);
        raw_lvl = 3'b111;
        run(5);
        chk("t5_111_e4", 8'b101_1_0_1_0_1);
        run(1);
        chk("t5_111", 8'b111_1_0_0_1_1);

        // Reset mid-debounce clears everything at once.
        do_reset(3'b000, 1'b0, 1'b0);
        run(6);
        chk("t6_valid", 8'b000_0_0_0_0_1);
        raw_dry = 1'b1;
        run(4);
        chk("t6_pending", 8'b000_0_0_0_0_1);
        RESET = 1'b0;
        #1;
        chk("t6_async", 8'h00);
        run(2);
        chk("t6_held", 8'h00);
        RESET = 1'b1;
        run(5);
        chk("t6_e5", 8'b000_0_0_0_0_0);
        run(1);
        chk("t6_e6", 8'b000_1_0_0_0_1);
        run(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
